demux_1to5_reg: RTL
===================

Name: demux_1to5_reg

Overview:
- Write-side counterpart to the datapath's 5-to-1 source selectors.
- Takes one WIDTH-bit value and a 3-bit destination select, and latches the value into one of five holding registers (or all five on broadcast).
- Each destination has a valid/ack handshake toward its consumer, plus sticky overrun and select-error flags.
- Used where one producer, such as the ALU result or a memory word, feeds several staged consumers in the multicycle datapath.

Parameters:
- WIDTH, 32, data width of I and O0..O4.
- BCAST_EN, 1, when 1, Select=3'b111 writes all five destinations; when 0, 3'b111 is treated as an invalid select.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- I  input  WIDTH  data to distribute.
- Select  input  3  destination index 0..4; 3'b111 is broadcast when BCAST_EN=1.
- Write  input  1  write strobe, sampled on the clk rising edge.
- Ack  input  5  per-destination consume strobe; bit n clears Valid[n].
- ErrClr  input  1  clears all Overrun bits and SelErr.
- O0, O1, O2, O3, O4  output  WIDTH each  registered holding values.
- Valid  output  5  bit n=1 means On holds an unconsumed value.
- Overrun  output  5  sticky; bit n=1 means On was overwritten while Valid[n]=1 and not acked in the same cycle.
- SelErr  output  1  sticky; a write was attempted with an invalid Select.

Behaviour:
- All state updates on the clk rising edge only. Outputs come straight from registers, with no combinational path from inputs to outputs.
- Reset (synchronous, active-high) has priority over everything, including a write in the same cycle:
  - O0..O4 = 0, Valid = 5'b0, Overrun = 5'b0, SelErr = 0.
  - Reset asserted mid-handshake drops all pending values.
- Write latency is 1 cycle. With Write=1 at edge k, On and Valid[n] show the new value after edge k.
- Target set T is computed when Write=1:
  - Select 0..4 gives T={Select}.
  - Select=7 with BCAST_EN=1 gives T={0..4}.
  - Select 5 or 6, or 7 with BCAST_EN=0, gives T={}.
- For each n in T: On <= I and Valid[n] <= 1.
- For each n not in T: On holds its value.
- Valid[n] next-state:
  - Write to n: 1. A write wins over a simultaneous Ack[n].
  - else Ack[n]=1: 0.
  - else: hold.
- Ack[n] while Valid[n]=0 is ignored and raises no error.
- Overrun[n] is set when n is in T, Valid[n]=1 and Ack[n]=0 in the same cycle. The overwrite still happens.
- Write to n with Ack[n]=1 and Valid[n]=1 is a legal back-to-back transfer and does not set Overrun.
- SelErr is set when Write=1 and T={}. No data or Valid register changes on an invalid select.
- Write=0 ignores Select and I entirely, and never sets SelErr.
- ErrClr=1 clears Overrun and SelErr. If a new error condition occurs in the same cycle, the set wins and the flag reads 1 afterwards. ErrClr does not affect O or Valid.
- Broadcast checks Overrun per destination independently, so only the bits whose Valid=1 and Ack=0 get set.
- No internal FSM beyond the per-destination Valid flags. Each destination is a two-state EMPTY/FULL machine:
  - EMPTY to FULL on write.
  - FULL to EMPTY on Ack without write.
  - FULL to FULL on write, with Overrun set if not acked.

Test Plan:
- Reset, then Write=1, Select=2, I=32'hDEADBEEF -> next cycle O2=DEADBEEF, Valid=5'b00100, other O=0, Overrun=0, SelErr=0.
- Fill dest 4 with I=32'h1, then write 32'h2 to dest 4 with Ack=0 -> O4=2, Valid[4]=1, Overrun=5'b10000. Assert ErrClr -> Overrun=0, O4 still 2.
- Dest 1 valid; same cycle Write Select=1 I=32'h55 and Ack=5'b00010 -> O1=55, Valid[1]=1, Overrun[1]=0.
- Write=1, Select=5, I=32'hFFFF -> SelErr=1, all O and Valid unchanged. Then ErrClr and a Select=6 write in the same cycle -> SelErr stays 1.
- BCAST_EN=1, Valid=5'b00001, Write Select=7 I=32'hA5A5A5A5 -> all O=A5A5A5A5, Valid=5'b11111, Overrun=5'b00001. Repeat with BCAST_EN=0 -> SelErr=1, no change.
- Valid=5'b11111, assert reset together with Write Select=0 I=32'h9 -> all O=0, Valid=0, flags=0. Ack while Valid=0 -> no change.

Source files
------------

// File: rtl/demux_1to5_reg.sv
// rtl/demux_1to5_reg.sv - 1-to-5 registered write demux with per-destination valid/ack and sticky error flags
module demux_1to5_reg #(
    parameter int WIDTH    = 32,
    parameter int BCAST_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] I,
    input  logic [2:0]       Select,
    input  logic             Write,
    input  logic [4:0]       Ack,
    input  logic             ErrClr,
    output logic [WIDTH-1:0] O0,
    output logic [WIDTH-1:0] O1,
    output logic [WIDTH-1:0] O2,
    output logic [WIDTH-1:0] O3,
    output logic [WIDTH-1:0] O4,
    output logic [4:0]       Valid,
    output logic [4:0]       Overrun,
    output logic             SelErr
);

    logic [WIDTH-1:0] data_q [5];
    logic [4:0]       valid_q, valid_d;
    logic [4:0]       overrun_q, overrun_d;
    logic             selerr_q, selerr_d;
    logic [4:0]       tgt;
    logic             sel_bad;

    // Target set decode; an invalid select leaves tgt empty so nothing is written.
    always_comb begin
        tgt     = 5'b00000;
        sel_bad = 1'b0;
        if (Write) begin
            if (Select <= 3'd4) begin
                tgt = 5'b00001 << Select;
            end else if (Select == 3'd7 && BCAST_EN != 0) begin
                tgt = 5'b11111;
            end else begin
                sel_bad = 1'b1;
            end
        end
    end

    // Write beats Ack; an error set in the same cycle as ErrClr wins.
    always_comb begin
        valid_d   = tgt | (valid_q & ~Ack);
        overrun_d = (ErrClr ? 5'b00000 : overrun_q) | (tgt & valid_q & ~Ack);
        selerr_d  = (ErrClr ? 1'b0 : selerr_q) | sel_bad;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 5'b00000;
            overrun_q <= 5'b00000;
            selerr_q  <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            selerr_q  <= selerr_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int n = 0; n < 5; n++) begin
            if (reset) begin
                data_q[n] <= '0;
            end else if (tgt[n]) begin
                data_q[n] <= I;
            end
        end
    end

    assign O0      = data_q[0];
    assign O1      = data_q[1];
    assign O2      = data_q[2];
    assign O3      = data_q[3];
    assign O4      = data_q[4];
    assign Valid   = valid_q;
    assign Overrun = overrun_q;
    assign SelErr  = selerr_q;

endmodule
